// File: rtl/addsub_seq_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_seq_accumulator
//  Description : Valid/ready sequencer around an external adder_subtractor that
//                runs multi-op accumulate sequences and emits one result each.
//  Revision    : 1.0
// ============================================================================
module addsub_seq_accumulator #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,

    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_sub_i,
    input  logic             in_acc_i,
    input  logic             in_last_i,

    output logic [WIDTH-1:0] as_a_o,
    output logic [WIDTH-1:0] as_b_o,
    output logic             as_sub_o,
    input  logic [WIDTH-1:0] as_result_i,
    input  logic             as_cout_i,
    input  logic             as_overflow_i,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic             out_cout_o,
    output logic             out_ovf_o,
    output logic             out_zero_o,
    output logic [CNT_W-1:0] out_count_o
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_OUT  = 2'd2;

    localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_op_sub;
    logic             r_op_last;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf_sticky;

    logic [WIDTH-1:0] r_out_result;
    logic             r_out_cout;
    logic             r_out_ovf;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_out_count;

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ovf_next;

    assign w_accept = in_valid_i & w_ready;

    // A signed overflow clamps toward the sign of operand A: the true result
    // always lies on the same side of zero as A when overflow occurs.
    assign w_acc_next   = (SAT_EN && as_overflow_i)
                        ? (r_op_a[WIDTH-1] ? c_SAT_MIN : c_SAT_MAX)
                        : as_result_i;
    assign w_count_next = (r_count == c_CNT_MAX) ? r_count : r_count + 1'b1;
    assign w_ovf_next   = r_ovf_sticky | as_overflow_i;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr_i) begin
            w_state_next = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: if (w_accept)    w_state_next = c_S_EXEC;
                c_S_EXEC:                  w_state_next = r_op_last ? c_S_OUT : c_S_IDLE;
                c_S_OUT:  if (out_ready_i) w_state_next = c_S_IDLE;
                default:                   w_state_next = c_S_IDLE;
            endcase
        end
    end

    // Ready is masked by reset so nothing is offered while rst_ni is low.
    always_comb begin
        w_ready     = rst_ni & (r_state == c_S_IDLE) & ~clr_i;
        out_valid_o = (r_state == c_S_OUT);
    end

    assign in_ready_o = w_ready;

    // ---------------------------------------------------------- operand stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_sub  <= 1'b0;
            r_op_last <= 1'b0;
        end else if (w_accept) begin
            r_op_a    <= in_acc_i ? r_acc : in_a_i;
            r_op_b    <= in_b_i;
            r_op_sub  <= in_sub_i;
            r_op_last <= in_last_i;
        end
    end

    assign as_a_o   = r_op_a;
    assign as_b_o   = r_op_b;
    assign as_sub_o = r_op_sub;

    // ------------------------------------------------- accumulator and result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_ovf_sticky <= 1'b0;
            r_out_result <= '0;
            r_out_cout   <= 1'b0;
            r_out_ovf    <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_count  <= '0;
        end else if (clr_i) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_ovf_sticky <= 1'b0;
            r_out_result <= '0;
            r_out_cout   <= 1'b0;
            r_out_ovf    <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_count  <= '0;
        end else begin
            case (r_state)
                c_S_EXEC: begin
                    r_acc        <= w_acc_next;
                    r_count      <= w_count_next;
                    r_ovf_sticky <= w_ovf_next;
                    if (r_op_last) begin
                        r_out_result <= w_acc_next;
                        r_out_cout   <= as_cout_i;
                        r_out_ovf    <= w_ovf_next;
                        r_out_zero   <= (w_acc_next == '0);
                        r_out_count  <= w_count_next;
                    end
                end
                c_S_OUT: begin
                    // Emission closes the sequence; the next one starts from zero.
                    if (out_ready_i) begin
                        r_acc        <= '0;
                        r_count      <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_out_result <= '0;
                        r_out_cout   <= 1'b0;
                        r_out_ovf    <= 1'b0;
                        r_out_zero   <= 1'b0;
                        r_out_count  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_result_o = r_out_result;
    assign out_cout_o   = r_out_cout;
    assign out_ovf_o    = r_out_ovf;
    assign out_zero_o   = r_out_zero;
    assign out_count_o  = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_seq_accumulator
//  Description : Runs a saturating and a wrapping instance side by side against
//                an arithmetic reference model of each.
//  Revision    : 1.0
// ============================================================================
module tb_addsub_seq_accumulator;

    localparam int W  = 8;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         in_acc = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;

    // index 0: SAT_EN=1, index 1: SAT_EN=0
    logic          rdy [2];
    logic          vld [2];
    logic [W-1:0]  as_a [2];
    logic [W-1:0]  as_b [2];
    logic          as_sub [2];
    logic [W-1:0]  as_res [2];
    logic          as_cout [2];
    logic          as_ovf [2];
    logic [W-1:0]  o_res [2];
    logic          o_cout [2];
    logic          o_ovf [2];
    logic          o_zero [2];
    logic [CW-1:0] o_cnt [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [W-1:0] w_bb;
        logic [W:0]   w_sum;
        assign w_bb      = as_sub[k] ? ~as_b[k] : as_b[k];
        assign w_sum     = {1'b0, as_a[k]} + {1'b0, w_bb} + {{W{1'b0}}, as_sub[k]};
        assign as_res[k] = w_sum[W-1:0];
        assign as_cout[k] = w_sum[W];
        assign as_ovf[k] = (as_a[k][W-1] == w_bb[W-1]) && (w_sum[W-1] != as_a[k][W-1]);

        addsub_seq_accumulator #(.WIDTH(W), .SAT_EN(k == 0), .CNT_W(CW)) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
            .in_valid_i(in_valid), .in_ready_o(rdy[k]),
            .in_a_i(in_a), .in_b_i(in_b), .in_sub_i(in_sub),
            .in_acc_i(in_acc), .in_last_i(in_last),
            .as_a_o(as_a[k]), .as_b_o(as_b[k]), .as_sub_o(as_sub[k]),
            .as_result_i(as_res[k]), .as_cout_i(as_cout[k]), .as_overflow_i(as_ovf[k]),
            .out_valid_o(vld[k]), .out_ready_i(out_ready),
            .out_result_o(o_res[k]), .out_cout_o(o_cout[k]), .out_ovf_o(o_ovf[k]),
            .out_zero_o(o_zero[k]), .out_count_o(o_cnt[k])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    int m_acc [2];
    bit m_ovf [2];
    bit m_cout [2];
    int m_cnt;
    int m_opa [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_ovf[k] = 0; m_cout[k] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_op(input int a, input int b, input bit sub, input bit acc);
        int ua, sa, sb, tu, ts;
        bit ovf;
        for (int k = 0; k < 2; k++) begin
            ua = acc ? m_acc[k] : a;
            m_opa[k] = ua;
            sa = (ua > 127) ? ua - 256 : ua;
            sb = (b > 127) ? b - 256 : b;
            ts = sub ? sa - sb : sa + sb;
            tu = sub ? ua - b : ua + b;
            m_cout[k] = sub ? (ua >= b) : (tu > 255);
            ovf = (ts > 127) || (ts < -128);
            m_ovf[k] = m_ovf[k] | ovf;
            if (k == 0 && ovf) m_acc[k] = (ts > 127) ? 127 : 128;
            else               m_acc[k] = tu & 255;
        end
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic check_out(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_vld"},  32'(vld[k]),    32'd1);
            check({tag, "_res"},  32'(o_res[k]),  32'(m_acc[k]));
            check({tag, "_cout"}, 32'(o_cout[k]), 32'(m_cout[k]));
            check({tag, "_ovf"},  32'(o_ovf[k]),  32'(m_ovf[k]));
            check({tag, "_zero"}, 32'(o_zero[k]), 32'(m_acc[k] == 0));
            check({tag, "_cnt"},  32'(o_cnt[k]),  32'(m_cnt));
        end
    endtask

    // Called at posedge+1 with both instances idle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit sub,
                         input bit acc, input bit last, input string tag);
        int budget = 20;
        while (!rdy[0] && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check({tag, "_rdy_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_acc = acc; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_op(int'(a), int'(b), sub, acc);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_exec_vld"}, 32'(vld[k]),  32'd0);
            check({tag, "_exec_rdy"}, 32'(rdy[k]),  32'd0);
            check({tag, "_as_a"},     32'(as_a[k]), 32'(m_opa[k]));
        end
        @(posedge clk); #1;
        if (last) begin
            check_out(tag);
        end else begin
            for (int k = 0; k < 2; k++) begin
                check({tag, "_idle_rdy"}, 32'(rdy[k]), 32'd1);
                check({tag, "_idle_vld"}, 32'(vld[k]), 32'd0);
            end
        end
    endtask

    task automatic drain(input int hold, input string tag);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_out({tag, "_hold"});
            check({tag, "_hold_rdy"}, 32'(rdy[0]), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check({tag, "_done_vld"}, 32'(vld[k]), 32'd0);
            check({tag, "_done_rdy"}, 32'(rdy[k]), 32'd1);
        end
    endtask

    task automatic check_zeroed(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_vld"}, 32'(vld[k]),   32'd0);
            check({tag, "_rdy"}, 32'(rdy[k]),   32'd0);
            check({tag, "_asa"}, 32'(as_a[k]),  32'd0);
            check({tag, "_asb"}, 32'(as_b[k]),  32'd0);
            check({tag, "_res"}, 32'(o_res[k]), 32'd0);
            check({tag, "_cnt"}, 32'(o_cnt[k]), 32'd0);
        end
    endtask

    initial begin
        int len;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_zeroed("reset");
        rst_n = 1'b1;
        #1;
        check("post_reset_rdy", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;

        issue(8'd5, 8'd3, 1'b0, 1'b0, 1'b1, "add53");
        check("add53_const", 32'(o_res[0]), 32'h08);
        drain(0, "add53");

        issue(8'd3, 8'd5, 1'b1, 1'b0, 1'b1, "sub35");
        check("sub35_const", 32'(o_res[0]), 32'hFE);
        check("sub35_cout",  32'(o_cout[0]), 32'd0);
        drain(0, "sub35");

        issue(8'd5, 8'd5, 1'b1, 1'b0, 1'b1, "sub55");
        check("sub55_zero", 32'(o_zero[0]), 32'd1);
        check("sub55_cout", 32'(o_cout[0]), 32'd1);
        drain(0, "sub55");

        // 100+50+10: clamps at 0x7F when saturating; wraps to 160 = 0xA0 otherwise.
        issue(8'd100, 8'd0,  1'b0, 1'b0, 1'b0, "sat1");
        issue(8'd0,   8'd50, 1'b0, 1'b1, 1'b0, "sat2");
        issue(8'd0,   8'd10, 1'b0, 1'b1, 1'b1, "sat3");
        check("sat_const",  32'(o_res[0]), 32'h7F);
        check("wrap_const", 32'(o_res[1]), 32'hA0);
        check("sat_cnt3",   32'(o_cnt[0]), 32'd3);
        drain(5, "sat");

        // clear while the second op executes
        issue(8'd1, 8'd2, 1'b0, 1'b0, 1'b0, "clr1");
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_sub = 1'b0; in_acc = 1'b1; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr = 1'b1;
        #1;
        check("clr_rdy", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        model_reset();
        repeat (2) begin
            check("clr_novld", 32'(vld[0]) | 32'(vld[1]), 32'd0);
            @(posedge clk); #1;
        end
        issue(8'd0, 8'd7, 1'b0, 1'b1, 1'b1, "clr2");
        check("clr2_const", 32'(o_res[0]), 32'h07);
        drain(0, "clr2");

        // reset during EXEC
        in_valid = 1'b1; in_a = 8'd33; in_b = 8'd44; in_sub = 1'b0; in_acc = 1'b0; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zeroed("rst_exec");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("rst_exec_rdy", 32'(rdy[0]), 32'd1);

        // reset while a result is pending
        issue(8'd9, 8'd9, 1'b0, 1'b0, 1'b1, "rst_out");
        rst_n = 1'b0;
        #1;
        check_zeroed("rst_out");
        check("rst_out_cout", 32'(o_cout[0]) | 32'(o_ovf[0]) | 32'(o_zero[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        issue(8'd0, 8'd4, 1'b0, 1'b1, 1'b1, "post_rst");
        check("post_rst_const", 32'(o_res[0]), 32'h04);
        drain(1, "post_rst");

        // counter saturation over a long sequence
        for (int i = 0; i < 259; i++) issue(8'd0, 8'd1, 1'b0, 1'b1, 1'b0, "long");
        issue(8'd0, 8'd1, 1'b0, 1'b1, 1'b1, "long_last");
        check("cnt_sat_const", 32'(o_cnt[0]), 32'd255);
        drain(0, "long");

        for (int s = 0; s < 150; s++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                      (i == len - 1), "rnd");
            end
            drain($urandom_range(0, 3), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
